// File: rtl/morse_key_decoder.sv
// Morse key receiver: synchronises and debounces a raw key, times presses as dot/dash,
// and emits the assembled (length, pattern) character after an inter-character gap.
module morse_key_decoder #(
  parameter int unsigned DEBOUNCE_TICKS = 10,
  parameter int unsigned DASH_TICKS     = 150,
  parameter int unsigned GAP_TICKS      = 300,
  parameter int unsigned CNT_W          = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       key_in,
  output logic [2:0] morse_len,
  output logic [4:0] morse_pattern,
  output logic       char_valid,
  output logic       char_err,
  output logic       busy,
  output logic       key_db
);

  localparam logic [CNT_W-1:0] DbLast  = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] DashThr = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] GapThr  = CNT_W'(GAP_TICKS);
  localparam logic [2:0]       MaxElem = 3'd5;

  typedef enum logic [1:0] {StIdle, StPress, StGap, StEmit} state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             key_db_q, key_db_d;
  logic             db_prev_q;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] dur_cnt_q, dur_cnt_d;
  logic [CNT_W-1:0] dur_inc;
  logic [2:0]       count_q, count_d;
  logic [4:0]       shift_q, shift_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       len_q, len_d;
  logic [4:0]       pattern_q, pattern_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             rise, fall;

  assign rise    = key_db_q & ~db_prev_q;
  assign fall    = ~key_db_q & db_prev_q;
  assign dur_inc = (dur_cnt_q == '1) ? dur_cnt_q : dur_cnt_q + 1'b1;

  // Debounce: count ticks while the synchronised level disagrees with key_db.
  always_comb begin
    db_cnt_d = db_cnt_q;
    key_db_d = key_db_q;
    if (sync2_q == key_db_q) begin
      db_cnt_d = '0;
    end else if (tick) begin
      if (db_cnt_q == DbLast) begin
        key_db_d = ~key_db_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    dur_cnt_d = dur_cnt_q;
    count_d   = count_q;
    shift_d   = shift_q;
    ovf_d     = ovf_q;
    case (state_q)
      StIdle: begin
        dur_cnt_d = '0;
        count_d   = '0;
        shift_d   = '0;
        ovf_d     = 1'b0;
        if (rise) state_d = StPress;
      end
      StPress: begin
        if (fall) begin
          if (count_q < MaxElem) begin
            shift_d = {shift_q[3:0], (dur_cnt_q >= DashThr)};
            count_d = count_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
          dur_cnt_d = '0;
          state_d   = StGap;
        end else if (tick) begin
          dur_cnt_d = dur_inc;
        end
      end
      StGap: begin
        // A new press on the threshold cycle still belongs to this character.
        if (rise) begin
          dur_cnt_d = '0;
          state_d   = StPress;
        end else if (dur_cnt_q == GapThr) begin
          state_d = StEmit;
        end else if (tick) begin
          dur_cnt_d = dur_inc;
        end
      end
      StEmit: begin
        ovf_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered against the next state so they line up with EMIT.
  always_comb begin
    len_d     = len_q;
    pattern_d = pattern_q;
    err_d     = err_q;
    valid_d   = (state_d == StEmit);
    busy_d    = (state_d == StPress) || (state_d == StGap);
    if (state_d == StEmit) begin
      len_d     = ovf_q ? 3'd0 : count_q;
      pattern_d = ovf_q ? 5'd0 : shift_q;
      err_d     = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      key_db_q  <= 1'b0;
      db_prev_q <= 1'b0;
      db_cnt_q  <= '0;
      dur_cnt_q <= '0;
      count_q   <= '0;
      shift_q   <= '0;
      ovf_q     <= 1'b0;
      len_q     <= '0;
      pattern_q <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= key_in;
      sync2_q   <= sync1_q;
      key_db_q  <= key_db_d;
      db_prev_q <= key_db_q;
      db_cnt_q  <= db_cnt_d;
      dur_cnt_q <= dur_cnt_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      ovf_q     <= ovf_d;
      len_q     <= len_d;
      pattern_q <= pattern_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign morse_len     = len_q;
  assign morse_pattern = pattern_q;
  assign char_err      = err_q;
  assign char_valid    = valid_q;
  assign busy          = busy_q;
  assign key_db        = key_db_q;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Bench for morse_key_decoder: directed and random key timings checked against a
// character-level model built from press/release durations.
module tb_morse_key_decoder;

  localparam int DashTicks = 150;
  localparam int GapTicks  = 300;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       tick   = 1'b0;
  logic       key_in = 1'b0;
  logic [2:0] morse_len;
  logic [4:0] morse_pattern;
  logic       char_valid;
  logic       char_err;
  logic       busy;
  logic       key_db;

  int tests = 0;
  int fails = 0;
  int press_q[$];
  int gap_q[$];
  int exp_len[$], exp_pat[$], exp_err[$];
  int cap_len[$], cap_pat[$], cap_err[$];
  logic db_seen   = 1'b0;
  logic busy_seen = 1'b0;

  morse_key_decoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .key_in       (key_in),
    .morse_len    (morse_len),
    .morse_pattern(morse_pattern),
    .char_valid   (char_valid),
    .char_err     (char_err),
    .busy         (busy),
    .key_db       (key_db)
  );

  always #20 clk = ~clk;

  // One-clk tick every 4 clk, changed on the falling edge.
  initial begin : tick_gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      tick = (ph == 0);
      ph = (ph + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (char_valid) begin
      cap_len.push_back(int'(morse_len));
      cap_pat.push_back(int'(morse_pattern));
      cap_err.push_back(int'(char_err));
    end
    if (key_db) db_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(int n);
    repeat (n) @(posedge tick);
  endtask

  task automatic hold(logic lvl, int n);
    key_in = lvl;
    wait_ticks(n);
  endtask

  task automatic add(int p, int g);
    press_q.push_back(p);
    gap_q.push_back(g);
  endtask

  task automatic expect_char(int len, int pat, int err);
    exp_len.push_back(len);
    exp_pat.push_back(pat);
    exp_err.push_back(err);
  endtask

  // Character-level model: elements accumulate until a release of GapTicks or more.
  task automatic model();
    int n   = 0;
    int pat = 0;
    for (int i = 0; i < press_q.size(); i++) begin
      n++;
      if (n <= 5) pat = pat * 2 + ((press_q[i] >= DashTicks) ? 1 : 0);
      if (gap_q[i] >= GapTicks) begin
        if (n > 5) expect_char(0, 0, 1);
        else expect_char(n, pat, 0);
        n   = 0;
        pat = 0;
      end
    end
  endtask

  task automatic play();
    for (int i = 0; i < press_q.size(); i++) begin
      hold(1'b1, press_q[i]);
      hold(1'b0, gap_q[i]);
    end
    wait_ticks(5);
    press_q.delete();
    gap_q.delete();
  endtask

  task automatic check_chars(string tag);
    chk({tag, ".count"}, 32'(cap_len.size()), 32'(exp_len.size()));
    for (int i = 0; i < cap_len.size() && i < exp_len.size(); i++) begin
      chk($sformatf("%s[%0d].len", tag, i), 32'(cap_len[i]), 32'(exp_len[i]));
      chk($sformatf("%s[%0d].pat", tag, i), 32'(cap_pat[i]), 32'(exp_pat[i]));
      chk($sformatf("%s[%0d].err", tag, i), 32'(cap_err[i]), 32'(exp_err[i]));
    end
    cap_len.delete(); cap_pat.delete(); cap_err.delete();
    exp_len.delete(); exp_pat.delete(); exp_err.delete();
  endtask

  task automatic check_outputs_zero(string tag);
    chk({tag, ".len"}, 32'(morse_len), 32'd0);
    chk({tag, ".pat"}, 32'(morse_pattern), 32'd0);
    chk({tag, ".valid"}, 32'(char_valid), 32'd0);
    chk({tag, ".err"}, 32'(char_err), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".key_db"}, 32'(key_db), 32'd0);
  endtask

  initial begin
    #10 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    wait_ticks(3);

    // Dot then dash
    add(50, 80); add(200, 400);
    model(); play(); check_chars("dotdash");
    chk("dotdash.hold_len", 32'(morse_len), 32'd2);
    chk("dotdash.hold_pat", 32'(morse_pattern), 32'd1);

    // Five dashes, then six dashes (overflow)
    for (int i = 0; i < 5; i++) add(200, (i == 4) ? 400 : 80);
    for (int i = 0; i < 6; i++) add(200, (i == 5) ? 400 : 80);
    model(); play(); check_chars("dashes");

    // Short glitches while idle must be ignored
    db_seen   = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 5);
      hold(1'b0, 20);
    end
    chk("glitch.key_db", 32'(db_seen), 32'd0);
    chk("glitch.busy", 32'(busy_seen), 32'd0);
    chk("glitch.valid", 32'(cap_len.size()), 32'd0);

    // 3-tick dropout inside a 100-tick press stays one dot
    hold(1'b1, 45); hold(1'b0, 3); hold(1'b1, 52); hold(1'b0, 400);
    wait_ticks(5);
    expect_char(1, 0, 0);
    check_chars("dropout");

    // Thresholds: 150 dash, 149 dot, 299 continues, 301 ends
    add(150, 400); add(149, 400);
    add(100, 299); add(100, 400);
    add(100, 301); add(100, 400);
    model(); play(); check_chars("bound");

    // Back-to-back: held outputs between the two pulses
    add(60, 400);
    model(); play(); check_chars("b2b1");
    hold(1'b1, 200);
    chk("b2b.hold_len", 32'(morse_len), 32'd1);
    chk("b2b.hold_pat", 32'(morse_pattern), 32'd0);
    chk("b2b.busy", 32'(busy), 32'd1);
    hold(1'b0, 400);
    wait_ticks(5);
    expect_char(1, 1, 0);
    check_chars("b2b2");

    // Reset during the second element's press
    hold(1'b1, 50); hold(1'b0, 80); hold(1'b1, 100);
    @(negedge clk) rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    key_in = 1'b0;
    wait_ticks(20);
    @(negedge clk) rst_n = 1'b1;
    wait_ticks(400);
    chk("midreset.no_valid", 32'(cap_len.size()), 32'd0);
    add(60, 400);
    model(); play(); check_chars("postreset");

    // Random characters of 1..6 elements
    for (int c = 0; c < 4; c++) begin
      int n;
      n = int'($urandom_range(1, 6));
      for (int e = 0; e < n; e++) begin
        int p, g;
        p = ($urandom_range(0, 1) == 1) ? int'($urandom_range(150, 220))
                                        : int'($urandom_range(12, 149));
        g = (e == n - 1) ? int'($urandom_range(320, 380)) : int'($urandom_range(15, 200));
        add(p, g);
      end
    end
    model(); play(); check_chars("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/morse_key_decoder.md
Name: morse_key_decoder

Overview:
- Receive-side counterpart of the keypad-to-buzzer Morse path. Samples a raw telegraph/push-button key, debounces it, and times each press as dot or dash.
- Detects the inter-character gap and emits the assembled (length, pattern) pair with a one-cycle valid strobe.
- Output format matches the morse_len/morse_pattern bus driven by the encoder, so a downstream inverse lookup or loopback checker can consume it directly.
- All timing is counted in ticks of an external 1 kHz enable (one tick = 1 ms).

Parameters:
DEBOUNCE_TICKS, 10, ticks the synchronized key must be stable before the debounced level changes
DASH_TICKS, 150, press length >= this is a dash; shorter is a dot
GAP_TICKS, 300, release length reaching this ends the character
CNT_W, 10, width of the duration counters; counters saturate at 2^CNT_W-1

Ports:
clk            in   1  system clock (25 MHz)
rst_n          in   1  asynchronous reset, active-low
tick           in   1  1 kHz enable, one clk wide, synchronous to clk
key_in         in   1  raw key, active-high, asynchronous to clk
morse_len      out  3  element count of last character (1..5; 0 on error)
morse_pattern  out  5  elements, 1=dash 0=dot; first element in bit [morse_len-1], last in bit 0; unused upper bits 0
char_valid     out  1  one-clk pulse: new character on morse_len/morse_pattern/char_err
char_err       out  1  last character had more than 5 elements
busy           out  1  high while in PRESS or GAP
key_db         out  1  debounced key level (debug)

Behaviour:
- Reset (async, rst_n low): all outputs 0. Synchronizer flops, debounce state, counters, shift register and element count cleared. FSM -> IDLE.
- Synchronizer:
  - key_in passes through 2 flops on clk.
  - Debounce counter advances only on tick. It resets whenever the synchronized level equals key_db.
  - key_db toggles when the synchronized level has differed from key_db for DEBOUNCE_TICKS consecutive ticks.
- Edge detection: rise/fall are one-clk pulses derived from key_db versus its previous-clk value.
- FSM states: IDLE, PRESS, GAP, EMIT.
  - IDLE: waits for rise -> PRESS. Clears dur_cnt, element count and shift register.
  - PRESS:
    - dur_cnt increments on tick (saturating).
    - On fall: element = (dur_cnt >= DASH_TICKS).
    - If count < 5: shift_reg <= {shift_reg[3:0], element} and count++. Otherwise set ovf.
    - Clear dur_cnt and go to GAP.
  - GAP:
    - dur_cnt increments on tick.
    - rise before dur_cnt reaches GAP_TICKS -> PRESS with dur_cnt cleared.
    - dur_cnt == GAP_TICKS -> EMIT.
    - If rise and threshold hit on the same clk, rise wins (-> PRESS).
  - EMIT, lasts one clk:
    - char_valid = 1.
    - If ovf: morse_len = 0, morse_pattern = 0, char_err = 1.
    - Otherwise: morse_len = count, morse_pattern = shift_reg, char_err = 0.
    - Next state IDLE; ovf cleared.
- Output holding: morse_len, morse_pattern and char_err are registered and held until the next EMIT. char_valid is high for exactly one clk per character.
- busy is high in PRESS and GAP, low in IDLE and EMIT.
- Latency:
  - Release tick to EMIT is GAP_TICKS ticks plus at most 2 clk.
  - key_in to key_db is 2 clk plus DEBOUNCE_TICKS ticks.
- Stuck key: a press held indefinitely saturates dur_cnt at 2^CNT_W-1, remains a dash, and produces no output until release.
- A character is never emitted without at least one element.
- tick asserted on every clk is legal; all counting then runs at clk rate.
- Reset asserted mid-character discards the partial character with no char_valid.

Test Plan:
- Dot-dash: bench runs tick every 4 clk. Press 50 ticks, release 80, press 200, release 400 -> one char_valid with morse_len=2, morse_pattern=5'b00001, char_err=0.
- Five dashes (200 press / 80 gap each), then a 400-tick release -> morse_len=5, morse_pattern=5'b11111. A sixth dash -> char_valid with char_err=1, morse_len=0, morse_pattern=0.
- Bounce rejection: 5-tick glitches on key_in while idle -> key_db stays 0, busy stays 0, no char_valid. A 3-tick dropout inside a 100-tick press -> single dot, morse_len=1, morse_pattern=0.
- Threshold boundaries:
  - Press of exactly 150 ticks -> dash; 149 ticks -> dot.
  - Release of 299 ticks then press -> same character continues.
  - Release reaching 300 -> emit.
- Back-to-back characters: "dot, gap 400, dash, gap 400" -> two char_valid pulses. Outputs hold len=1/pattern=0 until the second pulse updates them to len=1/pattern=1.
- Reset mid-operation: assert rst_n low during PRESS of the second element -> all outputs 0 immediately, no char_valid. After release of reset, a fresh single dot decodes correctly.
